// File: rtl/vanilla_long_op_sched_if.sv
// Handshake bundle between execute, the shared divide engine, writeback and
// the long-op scheduler. Signal names keep their original port names so the
// surrounding pipeline wiring carries over unchanged.
interface vanilla_long_op_sched_if #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
);
  localparam int num_regs_lp = 2 ** reg_addr_width_p;

  // execute -> scheduler, integer divide/remainder
  logic                        idiv_v_i;
  logic [1:0]                  idiv_op_i;
  logic [reg_addr_width_p-1:0] idiv_rd_i;
  logic                        idiv_ready_o;

  // execute -> scheduler, FP divide/sqrt
  logic                        fdiv_v_i;
  logic                        fdiv_sqrt_i;
  logic [reg_addr_width_p-1:0] fdiv_rd_i;
  logic                        fdiv_ready_o;

  // scheduler <-> divide engine
  logic                        eng_v_o;
  logic [2:0]                  eng_op_o;
  logic                        eng_ready_i;
  logic                        eng_v_i;
  logic [data_width_p-1:0]     eng_data_i;
  logic                        eng_yumi_o;

  // scheduler -> writeback arbiter
  logic                        wb_v_o;
  logic                        wb_is_fp_o;
  logic [reg_addr_width_p-1:0] wb_rd_o;
  logic [data_width_p-1:0]     wb_data_o;
  logic                        wb_yumi_i;

  // hazard tracking for issue
  logic [num_regs_lp-1:0]      int_busy_o;
  logic [num_regs_lp-1:0]      fp_busy_o;

  // scheduler side
  modport slave (
    input  idiv_v_i, idiv_op_i, idiv_rd_i,
    output idiv_ready_o,
    input  fdiv_v_i, fdiv_sqrt_i, fdiv_rd_i,
    output fdiv_ready_o,
    output eng_v_o, eng_op_o,
    input  eng_ready_i, eng_v_i, eng_data_i,
    output eng_yumi_o,
    output wb_v_o, wb_is_fp_o, wb_rd_o, wb_data_o,
    input  wb_yumi_i,
    output int_busy_o, fp_busy_o
  );

  // execute / engine / writeback side
  modport master (
    output idiv_v_i, idiv_op_i, idiv_rd_i,
    input  idiv_ready_o,
    output fdiv_v_i, fdiv_sqrt_i, fdiv_rd_i,
    input  fdiv_ready_o,
    input  eng_v_o, eng_op_o,
    output eng_ready_i, eng_v_i, eng_data_i,
    input  eng_yumi_o,
    input  wb_v_o, wb_is_fp_o, wb_rd_o, wb_data_o,
    output wb_yumi_i,
    input  int_busy_o, fp_busy_o
  );
endinterface

// File: rtl/vanilla_long_op_sched.sv
// Long-op scheduler: shares one iterative divide engine between integer
// DIV/DIVU/REM/REMU and FP FDIV.S/FSQRT.S. One op in flight at a time,
// round-robin between the two requesters, destination busy bits for issue
// stalls, and a one-entry result buffer for the writeback arbiter.
module vanilla_long_op_sched #(
  parameter int data_width_p     = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  vanilla_long_op_sched_if.slave  bus
);
  localparam int num_regs_lp = 2 ** reg_addr_width_p;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RESULT = 2'd2
  } state_e;

  state_e                      state_r;
  logic                        prefer_fp_r;  // FP wins a tie when set
  logic                        wb_is_fp_r;
  logic [reg_addr_width_p-1:0] wb_rd_r;
  logic [data_width_p-1:0]     wb_data_r;
  logic [num_regs_lp-1:0]      int_busy_r;
  logic [num_regs_lp-1:0]      fp_busy_r;

  logic idle;
  logic req_any;
  logic grant_fp;
  logic launch;

  // Arbitration and launch handshake; purely combinational in IDLE
  always_comb begin
    idle     = (state_r == IDLE);
    req_any  = bus.idiv_v_i | bus.fdiv_v_i;
    grant_fp = bus.fdiv_v_i & (~bus.idiv_v_i | prefer_fp_r);
    launch   = idle & req_any & bus.eng_ready_i;

    bus.eng_v_o = idle & req_any;
    bus.eng_op_o = '0;
    if (bus.eng_v_o) begin
      bus.eng_op_o = grant_fp ? {1'b1, 1'b0, bus.fdiv_sqrt_i}
                              : {1'b0, bus.idiv_op_i};
    end
    bus.idiv_ready_o = launch & ~grant_fp;
    bus.fdiv_ready_o = launch &  grant_fp;
    bus.eng_yumi_o   = (state_r == BUSY) & bus.eng_v_i;
  end

  // Registered outputs toward writeback and issue
  always_comb begin
    bus.wb_v_o     = (state_r == RESULT);
    bus.wb_is_fp_o = wb_is_fp_r;
    bus.wb_rd_o    = wb_rd_r;
    bus.wb_data_o  = wb_data_r;
    bus.int_busy_o = int_busy_r;
    bus.fp_busy_o  = fp_busy_r;
  end

  // Op sequencing FSM with result buffer and busy-bit bookkeeping.
  // Destination and regfile select are latched at launch straight into the
  // wb registers: the previous result has already been consumed by then, so
  // they still read stable for the whole RESULT phase.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= IDLE;
      prefer_fp_r <= 1'b0;
      wb_is_fp_r  <= 1'b0;
      wb_rd_r     <= '0;
      wb_data_r   <= '0;
      int_busy_r  <= '0;
      fp_busy_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch) begin
            state_r     <= BUSY;
            prefer_fp_r <= ~grant_fp;
            wb_is_fp_r  <= grant_fp;
            if (grant_fp) begin
              wb_rd_r                  <= bus.fdiv_rd_i;
              fp_busy_r[bus.fdiv_rd_i] <= 1'b1;
            end else begin
              wb_rd_r <= bus.idiv_rd_i;
              // x0 is hardwired, so it never becomes busy
              if (bus.idiv_rd_i != '0) int_busy_r[bus.idiv_rd_i] <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (bus.eng_v_i) begin
            state_r   <= RESULT;
            wb_data_r <= bus.eng_data_i;
          end
        end
        RESULT: begin
          if (bus.wb_yumi_i) begin
            state_r <= IDLE;
            if (wb_is_fp_r) fp_busy_r[wb_rd_r]  <= 1'b0;
            else            int_busy_r[wb_rd_r] <= 1'b0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  a_eng_v_only_in_busy: assert property (
    @(posedge clk_i) disable iff (reset_i) bus.eng_v_i |-> (state_r == BUSY));

  a_wb_yumi_only_with_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) bus.wb_yumi_i |-> (state_r == RESULT));

endmodule

// File: tb/tb_vanilla_long_op_sched.sv
// Bench for vanilla_long_op_sched: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a transaction model.
module tb_vanilla_long_op_sched;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic O = 1'b1;
  localparam logic Z = 1'b0;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  vanilla_long_op_sched_if #(.data_width_p(DW), .reg_addr_width_p(AW)) bus ();

  vanilla_long_op_sched #(.data_width_p(DW), .reg_addr_width_p(AW)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [1:0] iop, input logic [4:0] ird,
                       input logic fv, input logic fsq, input logic [4:0] frd,
                       input logic erdy, input logic ev, input logic [31:0] ed,
                       input logic wy);
    bus.idiv_v_i    = iv;
    bus.idiv_op_i   = iop;
    bus.idiv_rd_i   = ird;
    bus.fdiv_v_i    = fv;
    bus.fdiv_sqrt_i = fsq;
    bus.fdiv_rd_i   = frd;
    bus.eng_ready_i = erdy;
    bus.eng_v_i     = ev;
    bus.eng_data_i  = ed;
    bus.wb_yumi_i   = wy;
  endtask

  task automatic idle_inputs();
    drive(Z, 2'd0, 5'd0, Z, Z, 5'd0, Z, Z, 32'h0, Z);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  typedef struct {
    logic iv; logic [1:0] iop; logic [4:0] ird;
    logic fv; logic fsq; logic [4:0] frd;
    logic erdy; logic ev; logic [31:0] ed; logic wy;
    logic x_ev; logic [2:0] x_eop; logic x_ir; logic x_fr; logic x_yumi;
    logic x_wbv; logic x_wbfp; logic [4:0] x_wbrd; logic [31:0] x_wbd;
    logic [31:0] x_ib; logic [31:0] x_fb;
  } vec_t;

  vec_t vt[23];

  // transaction-level reference model state
  logic        m_pend, m_res, m_fp, m_last_fp;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  initial begin
    // inputs | expected outputs for the same cycle
    vt[0]  = '{O,2'd1,5'd5, Z,Z,5'd0, O, Z,32'h0, Z,  O,3'b001,O,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[1]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h20,32'h0};
    vt[2]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, O,32'h7, Z,  Z,3'b000,Z,Z,O, Z,Z,5'd0,32'h0, 32'h20,32'h0};
    vt[3]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, O,  Z,3'b000,Z,Z,Z, O,Z,5'd5,32'h7, 32'h20,32'h0};
    vt[4]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[5]  = '{O,2'd2,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  O,3'b010,O,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[6]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[7]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, O,32'hDEAD, Z, Z,3'b000,Z,Z,O, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[8]  = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, O,  Z,3'b000,Z,Z,Z, O,Z,5'd0,32'hDEAD, 32'h0,32'h0};
    vt[9]  = '{Z,2'd0,5'd0, O,O,5'd0, O, Z,32'h0, Z,  O,3'b101,Z,O,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[10] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h1};
    vt[11] = '{O,2'd0,5'd3, Z,Z,5'd0, Z, O,32'h3F800000, Z, Z,3'b000,Z,Z,O, Z,Z,5'd0,32'h0, 32'h0,32'h1};
    vt[12] = '{Z,2'd0,5'd0, Z,Z,5'd0, Z, Z,32'h0, O,  Z,3'b000,Z,Z,Z, O,O,5'd0,32'h3F800000, 32'h0,32'h1};
    vt[13] = '{O,2'd3,5'd3, O,Z,5'd9, Z, Z,32'h0, Z,  O,3'b011,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[14] = '{O,2'd3,5'd3, O,Z,5'd9, O, Z,32'h0, Z,  O,3'b011,O,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[15] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h8,32'h0};
    vt[16] = '{Z,2'd0,5'd0, O,Z,5'd9, O, O,32'h12345678, Z, Z,3'b000,Z,Z,O, Z,Z,5'd0,32'h0, 32'h8,32'h0};
    vt[17] = '{Z,2'd0,5'd0, O,Z,5'd9, O, Z,32'h0, O,  Z,3'b000,Z,Z,Z, O,Z,5'd3,32'h12345678, 32'h8,32'h0};
    vt[18] = '{Z,2'd0,5'd0, O,Z,5'd9, O, Z,32'h0, Z,  O,3'b100,Z,O,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};
    vt[19] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h200};
    vt[20] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, O,32'h55, Z, Z,3'b000,Z,Z,O, Z,Z,5'd0,32'h0, 32'h0,32'h200};
    vt[21] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, O,  Z,3'b000,Z,Z,Z, O,O,5'd9,32'h55, 32'h0,32'h200};
    vt[22] = '{Z,2'd0,5'd0, Z,Z,5'd0, O, Z,32'h0, Z,  Z,3'b000,Z,Z,Z, Z,Z,5'd0,32'h0, 32'h0,32'h0};

    // ---- reset state ----
    do_reset();
    #1;
    chk("rst_eng_v",   64'(bus.eng_v_o), 64'(0));
    chk("rst_eng_op",  64'(bus.eng_op_o), 64'(0));
    chk("rst_yumi",    64'(bus.eng_yumi_o), 64'(0));
    chk("rst_rdy",     64'({bus.idiv_ready_o, bus.fdiv_ready_o}), 64'(0));
    chk("rst_wb",      64'({bus.wb_v_o, bus.wb_is_fp_o, bus.wb_rd_o, bus.wb_data_o}), 64'(0));
    chk("rst_ibusy",   64'(bus.int_busy_o), 64'(0));
    chk("rst_fbusy",   64'(bus.fp_busy_o), 64'(0));

    // ---- directed vector table ----
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].iv, vt[i].iop, vt[i].ird, vt[i].fv, vt[i].fsq, vt[i].frd,
            vt[i].erdy, vt[i].ev, vt[i].ed, vt[i].wy);
      #1;
      chk($sformatf("v%0d_eng_v", i),  64'(bus.eng_v_o),      64'(vt[i].x_ev));
      chk($sformatf("v%0d_eng_op", i), 64'(bus.eng_op_o),     64'(vt[i].x_eop));
      chk($sformatf("v%0d_irdy", i),   64'(bus.idiv_ready_o), 64'(vt[i].x_ir));
      chk($sformatf("v%0d_frdy", i),   64'(bus.fdiv_ready_o), 64'(vt[i].x_fr));
      chk($sformatf("v%0d_yumi", i),   64'(bus.eng_yumi_o),   64'(vt[i].x_yumi));
      chk($sformatf("v%0d_wb_v", i),   64'(bus.wb_v_o),       64'(vt[i].x_wbv));
      if (vt[i].x_wbv) begin
        chk($sformatf("v%0d_wb_fp", i),   64'(bus.wb_is_fp_o), 64'(vt[i].x_wbfp));
        chk($sformatf("v%0d_wb_rd", i),   64'(bus.wb_rd_o),    64'(vt[i].x_wbrd));
        chk($sformatf("v%0d_wb_data", i), 64'(bus.wb_data_o),  64'(vt[i].x_wbd));
      end
      chk($sformatf("v%0d_ibusy", i), 64'(bus.int_busy_o), 64'(vt[i].x_ib));
      chk($sformatf("v%0d_fbusy", i), 64'(bus.fp_busy_o),  64'(vt[i].x_fb));
      next_cycle();
    end

    // ---- both requesters held valid: idiv, fdiv, idiv, fdiv ----
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic exp_fp;
      exp_fp = (k % 2) == 1;
      drive(O, 2'd0, 5'(k + 1), O, Z, 5'(k + 10), O, Z, 32'h0, Z);
      #1;
      chk($sformatf("rr%0d_eng_v", k), 64'(bus.eng_v_o), 64'(1));
      chk($sformatf("rr%0d_frdy", k),  64'(bus.fdiv_ready_o), 64'(exp_fp));
      chk($sformatf("rr%0d_irdy", k),  64'(bus.idiv_ready_o), 64'(!exp_fp));
      chk($sformatf("rr%0d_op", k),    64'(bus.eng_op_o), exp_fp ? 64'h4 : 64'h0);
      next_cycle();
      drive(O, 2'd0, 5'(k + 1), O, Z, 5'(k + 10), O, O, 32'(k + 100), Z);
      #1;
      chk($sformatf("rr%0d_busy_rdy", k), 64'({bus.idiv_ready_o, bus.fdiv_ready_o, bus.eng_v_o}), 64'(0));
      chk($sformatf("rr%0d_ibusy", k), 64'(bus.int_busy_o), exp_fp ? 64'(0) : 64'(32'(1) << (k + 1)));
      chk($sformatf("rr%0d_fbusy", k), 64'(bus.fp_busy_o),  exp_fp ? 64'(32'(1) << (k + 10)) : 64'(0));
      next_cycle();
      drive(O, 2'd0, 5'(k + 1), O, Z, 5'(k + 10), O, Z, 32'h0, O);
      #1;
      chk($sformatf("rr%0d_wb", k), 64'({bus.wb_v_o, bus.wb_is_fp_o, bus.wb_rd_o, bus.wb_data_o}),
          64'({1'b1, exp_fp, exp_fp ? 5'(k + 10) : 5'(k + 1), 32'(k + 100)}));
      next_cycle();
    end

    // ---- result held in RESULT for 5 cycles without yumi ----
    drive(O, 2'd1, 5'd7, Z, Z, 5'd0, O, Z, 32'h0, Z);
    next_cycle();
    drive(Z, 2'd0, 5'd0, Z, Z, 5'd0, O, O, 32'hABCD, Z);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(O, 2'd0, 5'd1, O, Z, 5'd2, O, Z, 32'h0, Z);
      #1;
      chk($sformatf("hold%0d_wb", k), 64'({bus.wb_v_o, bus.wb_is_fp_o, bus.wb_rd_o, bus.wb_data_o}),
          64'({1'b1, 1'b0, 5'd7, 32'hABCD}));
      chk($sformatf("hold%0d_rdy", k), 64'({bus.idiv_ready_o, bus.fdiv_ready_o, bus.eng_v_o}), 64'(0));
      chk($sformatf("hold%0d_ibusy", k), 64'(bus.int_busy_o), 64'h80);
      next_cycle();
    end
    drive(Z, 2'd0, 5'd0, Z, Z, 5'd0, O, Z, 32'h0, O);
    next_cycle();
    idle_inputs();
    #1;
    chk("hold_clear_ibusy", 64'(bus.int_busy_o), 64'(0));

    // ---- asynchronous reset while BUSY ----
    next_cycle();
    drive(O, 2'd0, 5'd4, Z, Z, 5'd0, O, Z, 32'h0, Z);
    next_cycle();
    drive(Z, 2'd0, 5'd0, Z, Z, 5'd0, O, O, 32'h99, Z);
    #1;
    chk("arst_pre_yumi", 64'(bus.eng_yumi_o), 64'(1));
    chk("arst_pre_ibusy", 64'(bus.int_busy_o), 64'h10);
    #1;
    reset_i = 1'b1;
    #1;
    chk("arst_ibusy", 64'(bus.int_busy_o), 64'(0));
    chk("arst_fbusy", 64'(bus.fp_busy_o), 64'(0));
    chk("arst_wb_v",  64'(bus.wb_v_o), 64'(0));
    chk("arst_yumi",  64'(bus.eng_yumi_o), 64'(0));
    idle_inputs();
    next_cycle();
    reset_i = 1'b0;
    next_cycle();
    drive(Z, 2'd0, 5'd0, O, Z, 5'd2, O, Z, 32'h0, Z);
    #1;
    chk("arst_relaunch_frdy", 64'(bus.fdiv_ready_o), 64'(1));
    chk("arst_relaunch_op",   64'(bus.eng_op_o), 64'h4);
    next_cycle();
    idle_inputs();
    #1;
    chk("arst_relaunch_fbusy", 64'(bus.fp_busy_o), 64'h4);

    // ---- random traffic vs. transaction model ----
    do_reset();
    m_pend = 1'b0; m_res = 1'b0; m_fp = 1'b0; m_last_fp = 1'b1;
    m_rd = 5'd0; m_data = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      logic iv, fv, fsq, erdy, ev, wy;
      logic [1:0] iop;
      logic [4:0] ird, frd;
      logic [31:0] ed, e_ib, e_fb;
      logic idle, e_ev, win_fp, e_launch;
      logic [2:0] e_op;
      iv   = 1'($urandom_range(0, 1));
      fv   = 1'($urandom_range(0, 1));
      fsq  = 1'($urandom_range(0, 1));
      iop  = 2'($urandom_range(0, 3));
      ird  = 5'($urandom_range(0, 31));
      frd  = 5'($urandom_range(0, 31));
      erdy = ($urandom_range(0, 3) != 0);
      ev   = m_pend && ($urandom_range(0, 3) == 0);
      wy   = m_res && ($urandom_range(0, 2) == 0);
      ed   = $urandom;
      drive(iv, iop, ird, fv, fsq, frd, erdy, ev, ed, wy);
      #1;
      idle     = !m_pend && !m_res;
      e_ev     = idle && (iv || fv);
      win_fp   = fv && (!iv || !m_last_fp);
      e_launch = e_ev && erdy;
      e_op     = !e_ev ? 3'b000 : (win_fp ? {2'b10, fsq} : {1'b0, iop});
      e_ib     = ((m_pend || m_res) && !m_fp && m_rd != 5'd0) ? (32'(1) << m_rd) : 32'h0;
      e_fb     = ((m_pend || m_res) && m_fp) ? (32'(1) << m_rd) : 32'h0;
      chk("rnd_eng_v", 64'(bus.eng_v_o), 64'(e_ev));
      chk("rnd_eng_op", 64'(bus.eng_op_o), 64'(e_op));
      chk("rnd_irdy", 64'(bus.idiv_ready_o), 64'(e_launch && !win_fp));
      chk("rnd_frdy", 64'(bus.fdiv_ready_o), 64'(e_launch && win_fp));
      chk("rnd_yumi", 64'(bus.eng_yumi_o), 64'(m_pend && ev));
      chk("rnd_wb_v", 64'(bus.wb_v_o), 64'(m_res));
      if (m_res) begin
        chk("rnd_wb", 64'({bus.wb_is_fp_o, bus.wb_rd_o, bus.wb_data_o}), 64'({m_fp, m_rd, m_data}));
      end
      chk("rnd_ibusy", 64'(bus.int_busy_o), 64'(e_ib));
      chk("rnd_fbusy", 64'(bus.fp_busy_o), 64'(e_fb));
      next_cycle();
      if (e_launch) begin
        m_pend = 1'b1; m_fp = win_fp; m_rd = win_fp ? frd : ird; m_last_fp = win_fp;
      end else if (m_pend && ev) begin
        m_pend = 1'b0; m_res = 1'b1; m_data = ed;
      end else if (m_res && wy) begin
        m_res = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
